// File: rtl/lc3_datapath_gen2_pkg.sv
// Shared types for the second-generation LC-3 datapath: load/gate bit positions,
// mux selects, ALU ops, memory sequencer states and the condition-code reset value.
package lc3_datapath_gen2_pkg;

    // Bit positions inside the 8-bit ld strobe vector
    typedef enum logic [2:0] {
        LD_MAR = 3'd0,
        LD_MDR = 3'd1,
        LD_IR  = 3'd2,
        LD_BEN = 3'd3,
        LD_CC  = 3'd4,
        LD_REG = 3'd5,
        LD_PC  = 3'd6,
        LD_LED = 3'd7
    } ld_e;

    // Bit positions inside the 4-bit gate vector
    typedef enum logic [1:0] {
        GATE_PC     = 2'd0,
        GATE_MDR    = 2'd1,
        GATE_ALU    = 2'd2,
        GATE_MARMUX = 2'd3
    } gate_e;

    typedef enum logic [1:0] {
        PCMUX_PC_PLUS1 = 2'd0,
        PCMUX_ADDR_SUM = 2'd1,
        PCMUX_DATA_BUS = 2'd2
    } pcmux_e;

    typedef enum logic [1:0] {
        ADDR2_ZERO  = 2'd0,
        ADDR2_OFF6  = 2'd1,
        ADDR2_OFF9  = 2'd2,
        ADDR2_OFF11 = 2'd3
    } addr2_e;

    typedef enum logic [1:0] {
        ALUK_ADD   = 2'd0,
        ALUK_AND   = 2'd1,
        ALUK_NOT   = 2'd2,
        ALUK_PASSA = 2'd3
    } aluk_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_REQ  = 2'd1,
        SEQ_DONE = 2'd2,
        SEQ_ERR  = 2'd3
    } seq_state_e;

    // {N,Z,P} after reset: zero flag set
    localparam logic [2:0] CC_RESET = 3'b010;

    // True when more than one bus gate is asserted (clearing the lowest set bit leaves something)
    function automatic logic gate_conflict(input logic [3:0] g);
        return ((g & (g - 4'd1)) != 4'd0);
    endfunction

endpackage

// File: rtl/lc3_datapath_gen2_if.sv
// Memory-bridge handshake between the datapath (master) and the memory/IO bridge (slave).
interface lc3_datapath_gen2_if #(
    parameter int DATA_W = 16
) ();
    logic              mem_req;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lc3_datapath_gen2_mem_seq.sv
// Memory-access sequencer: IDLE -> REQ -> DONE -> IDLE, REQ -> ERR when the bridge
// stays silent for TIMEOUT_CYC cycles. Handshake outputs come straight from registers;
// mdr_capture tells the datapath to take mem_rdata at the acknowledging edge of a read.
module lc3_datapath_gen2_mem_seq
    import lc3_datapath_gen2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic Clk,
    input  logic Reset,
    input  logic mem_start,
    input  logic mem_we,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_wr,
    output logic mem_done,
    output logic mem_busy,
    output logic mem_err,
    output logic mdr_capture
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    seq_state_e      state_r;
    seq_state_e      state_s;
    logic [CNT_W-1:0] cnt_r;
    logic            start_s;
    logic            wr_r;
    logic            req_r;
    logic            done_r;
    logic            busy_r;
    logic            err_r;

    // Next-state decode; a start is only honoured from IDLE
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (mem_start) begin
                    state_s = SEQ_REQ;
                    start_s = 1'b1;
                end else begin
                    state_s = SEQ_IDLE;
                end
            end
            SEQ_REQ: begin
                if (mem_ack) begin
                    state_s = SEQ_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = SEQ_ERR;
                end else begin
                    state_s = SEQ_REQ;
                end
            end
            SEQ_DONE: state_s = SEQ_IDLE;
            SEQ_ERR:  state_s = SEQ_IDLE;
            default:  state_s = SEQ_IDLE;
        endcase
    end

    // State, timeout counter, latched access type and registered handshake outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= SEQ_IDLE;
            cnt_r   <= CNT_ZERO;
            wr_r    <= 1'b0;
            req_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                wr_r  <= mem_we;
                cnt_r <= CNT_ZERO;
            end else if (state_r == SEQ_REQ) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            req_r  <= (state_s == SEQ_REQ);
            done_r <= (state_s == SEQ_DONE) || (state_s == SEQ_ERR);
            busy_r <= (state_s == SEQ_REQ) || (state_s == SEQ_ERR);
            err_r  <= err_r || (state_s == SEQ_ERR);
        end
    end

    assign mem_req     = req_r;
    assign mem_wr      = wr_r;
    assign mem_done    = done_r;
    assign mem_busy    = busy_r;
    assign mem_err     = err_r;
    assign mdr_capture = (state_r == SEQ_REQ) && mem_ack && !wr_r;

endmodule

// File: rtl/lc3_datapath_gen2.sv
// Second-generation LC-3 datapath: PC/IR/MAR/MDR, 8-entry register file, ALU, address
// adder, condition codes, BEN and LED latch, plus a handshaked memory sequencer.
// Optional build macro DP_BREAKPOINT_EN adds a sticky PC-load breakpoint comparator.
module lc3_datapath_gen2
    import lc3_datapath_gen2_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                LED_W       = 12,
    parameter logic [DATA_W-1:0] PC_RESET    = {DATA_W{1'b0}},
    parameter int                TIMEOUT_CYC = 64
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [7:0]         ld,
    input  logic [3:0]         gate,
    input  logic [1:0]         pcmux,
    input  logic [1:0]         addr2mux,
    input  logic [1:0]         aluk,
    input  logic               drmux,
    input  logic               sr1mux,
    input  logic               sr2mux,
    input  logic               addr1mux,
    input  logic               mem_start,
    input  logic               mem_we,
    lc3_datapath_gen2_if.master mem,
    output logic               mem_done,
    output logic               mem_busy,
    output logic               mem_err,
    output logic               bus_conflict,
    output logic [DATA_W-1:0]  IR,
    output logic [DATA_W-1:0]  MAR,
    output logic [DATA_W-1:0]  MDR,
    output logic [LED_W-1:0]   LED,
    output logic               BEN
`ifdef DP_BREAKPOINT_EN
    ,
    input  logic [DATA_W-1:0]  bp_addr,
    input  logic               bp_arm,
    output logic               bp_hit
`endif
);
    localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE_W  = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] pc_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] mar_r;
    logic [DATA_W-1:0] mdr_r;
    logic [LED_W-1:0]  led_r;
    logic              ben_r;
    logic [2:0]        cc_r;
    logic [DATA_W-1:0] regs_r [8];

    logic [2:0]        dr_s;
    logic [2:0]        sr1_s;
    logic [DATA_W-1:0] sr1_val_s;
    logic [DATA_W-1:0] sr2_val_s;
    logic [DATA_W-1:0] imm5_s;
    logic [DATA_W-1:0] off6_s;
    logic [DATA_W-1:0] off9_s;
    logic [DATA_W-1:0] off11_s;
    logic [DATA_W-1:0] alu_b_s;
    logic [DATA_W-1:0] alu_s;
    logic [DATA_W-1:0] addr1_s;
    logic [DATA_W-1:0] addr2_s;
    logic [DATA_W-1:0] addr_sum_s;
    logic [DATA_W-1:0] pc_plus1_s;
    logic [DATA_W-1:0] pc_next_s;
    logic [DATA_W-1:0] bus_s;
    logic [2:0]        cc_next_s;
    logic              ben_next_s;
    logic              seq_req_s;
    logic              mdr_capture_s;

    lc3_datapath_gen2_mem_seq #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_mem_seq (
        .Clk         (Clk),
        .Reset       (Reset),
        .mem_start   (mem_start),
        .mem_we      (mem_we),
        .mem_ack     (mem.mem_ack),
        .mem_req     (seq_req_s),
        .mem_wr      (mem.mem_wr),
        .mem_done    (mem_done),
        .mem_busy    (mem_busy),
        .mem_err     (mem_err),
        .mdr_capture (mdr_capture_s)
    );

    assign mem.mem_req   = seq_req_s;
    assign mem.mem_addr  = mar_r;
    assign mem.mem_wdata = mdr_r;

    // IR field decode: DR is IR[11:9] or R7; SR1 is IR[11:9] (sr1mux=0) or IR[8:6]
    assign dr_s      = drmux ? 3'd7 : ir_r[11:9];
    assign sr1_s     = sr1mux ? ir_r[8:6] : ir_r[11:9];
    assign sr1_val_s = regs_r[sr1_s];
    assign sr2_val_s = regs_r[ir_r[2:0]];

    assign imm5_s  = {{(DATA_W-5){ir_r[4]}},  ir_r[4:0]};
    assign off6_s  = {{(DATA_W-6){ir_r[5]}},  ir_r[5:0]};
    assign off9_s  = {{(DATA_W-9){ir_r[8]}},  ir_r[8:0]};
    assign off11_s = {{(DATA_W-11){ir_r[10]}}, ir_r[10:0]};

    assign alu_b_s = sr2mux ? imm5_s : sr2_val_s;

    // ALU operation select
    always_comb begin
        alu_s = ZERO_W;
        case (aluk)
            ALUK_ADD:   alu_s = sr1_val_s + alu_b_s;
            ALUK_AND:   alu_s = sr1_val_s & alu_b_s;
            ALUK_NOT:   alu_s = ~sr1_val_s;
            ALUK_PASSA: alu_s = sr1_val_s;
            default:    alu_s = ZERO_W;
        endcase
    end

    // Address adder operand select; sum wraps modulo 2^DATA_W
    always_comb begin
        addr2_s = ZERO_W;
        case (addr2mux)
            ADDR2_ZERO:  addr2_s = ZERO_W;
            ADDR2_OFF6:  addr2_s = off6_s;
            ADDR2_OFF9:  addr2_s = off9_s;
            ADDR2_OFF11: addr2_s = off11_s;
            default:     addr2_s = ZERO_W;
        endcase
    end

    assign addr1_s    = addr1mux ? sr1_val_s : pc_r;
    assign addr_sum_s = addr1_s + addr2_s;
    assign pc_plus1_s = pc_r + ONE_W;

    // Bus driver: exactly one gate selects a source, anything else floats to zero
    always_comb begin
        bus_s = ZERO_W;
        case (gate)
            4'b0001: bus_s = pc_r;
            4'b0010: bus_s = mdr_r;
            4'b0100: bus_s = alu_s;
            4'b1000: bus_s = addr_sum_s;
            default: bus_s = ZERO_W;
        endcase
    end

    assign bus_conflict = gate_conflict(gate);

    // PC source select; the unused encoding holds PC
    always_comb begin
        pc_next_s = pc_r;
        case (pcmux)
            PCMUX_PC_PLUS1: pc_next_s = pc_plus1_s;
            PCMUX_ADDR_SUM: pc_next_s = addr_sum_s;
            PCMUX_DATA_BUS: pc_next_s = bus_s;
            default:        pc_next_s = pc_r;
        endcase
    end

    // Signed condition codes from the bus; exactly one of N/Z/P is always set
    always_comb begin
        cc_next_s[2] = bus_s[DATA_W-1];
        cc_next_s[1] = (bus_s == ZERO_W);
        cc_next_s[0] = !bus_s[DATA_W-1] && (bus_s != ZERO_W);
    end

    assign ben_next_s = (ir_r[11] & cc_r[2]) | (ir_r[10] & cc_r[1]) | (ir_r[9] & cc_r[0]);

    // Architectural registers; MAR frozen while the sequencer is busy, MDR owned by a read ack
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r  <= PC_RESET;
            ir_r  <= ZERO_W;
            mar_r <= {DATA_W{1'b1}};
            mdr_r <= ZERO_W;
            led_r <= {LED_W{1'b0}};
            ben_r <= 1'b0;
            cc_r  <= CC_RESET;
        end else begin
            if (ld[LD_PC]) pc_r <= pc_next_s;
            else           pc_r <= pc_r;
            if (ld[LD_IR]) ir_r <= bus_s;
            else           ir_r <= ir_r;
            if (ld[LD_MAR] && !mem_busy) mar_r <= bus_s;
            else                         mar_r <= mar_r;
            if (mdr_capture_s)                   mdr_r <= mem.mem_rdata;
            else if (ld[LD_MDR] && !seq_req_s)   mdr_r <= bus_s;
            else                                 mdr_r <= mdr_r;
            if (ld[LD_LED]) led_r <= ir_r[LED_W-1:0];
            else            led_r <= led_r;
            if (ld[LD_BEN]) ben_r <= ben_next_s;
            else            ben_r <= ben_r;
            if (ld[LD_CC])  cc_r <= cc_next_s;
            else            cc_r <= cc_r;
        end
    end

    // Register file write port; reads above see the pre-edge contents
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= ZERO_W;
            end
        end else if (ld[LD_REG]) begin
            regs_r[dr_s] <= bus_s;
        end else begin
            regs_r[dr_s] <= regs_r[dr_s];
        end
    end

    assign IR  = ir_r;
    assign MAR = mar_r;
    assign MDR = mdr_r;
    assign LED = led_r;
    assign BEN = ben_r;

`ifdef DP_BREAKPOINT_EN
    logic bp_hit_r;

    // Sticky hit when an armed PC load writes the breakpoint address
    always_ff @(posedge Clk) begin
        if (Reset || !bp_arm) begin
            bp_hit_r <= 1'b0;
        end else if (ld[LD_PC] && (pc_next_s == bp_addr)) begin
            bp_hit_r <= 1'b1;
        end else begin
            bp_hit_r <= bp_hit_r;
        end
    end

    assign bp_hit = bp_hit_r;
`endif

endmodule

// File: tb/tb_lc3_datapath_gen2.sv
// Directed self-checking bench for lc3_datapath_gen2 (PC_RESET=0x0400, TIMEOUT_CYC=64).
// The bench plays the memory bridge; arbitrary bus values are introduced by reading them
// into MDR and gating MDR onto the bus.
module tb_lc3_datapath_gen2;

    localparam logic [7:0] L_MAR = 8'h01, L_MDR = 8'h02, L_IR  = 8'h04, L_BEN = 8'h08;
    localparam logic [7:0] L_CC  = 8'h10, L_REG = 8'h20, L_PC  = 8'h40, L_LED = 8'h80;
    localparam logic [3:0] G_PC  = 4'h1,  G_MDR = 4'h2,  G_ALU = 4'h4,  G_MARMUX = 4'h8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  ld;
    logic [3:0]  gate;
    logic [1:0]  pcmux, addr2mux, aluk;
    logic        drmux, sr1mux, sr2mux, addr1mux;
    logic        mem_start, mem_we;
    logic        mem_done, mem_busy, mem_err, bus_conflict;
    logic [15:0] IR, MAR, MDR;
    logic [11:0] LED;
    logic        BEN;
`ifdef DP_BREAKPOINT_EN
    logic [15:0] bp_addr;
    logic        bp_arm;
    logic        bp_hit;
`endif

    int checks   = 0;
    int failures = 0;
    int req_cnt;

    lc3_datapath_gen2_if #(.DATA_W(16)) mem_if ();

    lc3_datapath_gen2 #(
        .DATA_W      (16),
        .LED_W       (12),
        .PC_RESET    (16'h0400),
        .TIMEOUT_CYC (64)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ld           (ld),
        .gate         (gate),
        .pcmux        (pcmux),
        .addr2mux     (addr2mux),
        .aluk         (aluk),
        .drmux        (drmux),
        .sr1mux       (sr1mux),
        .sr2mux       (sr2mux),
        .addr1mux     (addr1mux),
        .mem_start    (mem_start),
        .mem_we       (mem_we),
        .mem          (mem_if.master),
        .mem_done     (mem_done),
        .mem_busy     (mem_busy),
        .mem_err      (mem_err),
        .bus_conflict (bus_conflict),
        .IR           (IR),
        .MAR          (MAR),
        .MDR          (MDR),
        .LED          (LED),
        .BEN          (BEN)
`ifdef DP_BREAKPOINT_EN
        ,
        .bp_addr      (bp_addr),
        .bp_arm       (bp_arm),
        .bp_hit       (bp_hit)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One cycle with the given load strobes and bus gates, then release them
    task automatic xfer(input logic [7:0] ld_v, input logic [3:0] gate_v);
        ld   = ld_v;
        gate = gate_v;
        step();
        ld   = 8'h00;
        gate = 4'h0;
    endtask

    // Read with an immediate ack returning data; leaves the sequencer back in IDLE
    task automatic mem_read(input logic [15:0] data);
        mem_start = 1'b1;
        mem_we    = 1'b0;
        step();
        mem_start        = 1'b0;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = data;
        step();
        mem_if.mem_ack = 1'b0;
        step();
        chk("rd_mdr", {16'h0, MDR}, {16'h0, data});
    endtask

    initial begin
        Reset = 1'b1; ld = 8'h00; gate = 4'h0; pcmux = 2'd0; addr2mux = 2'd0; aluk = 2'd0;
        drmux = 1'b0; sr1mux = 1'b0; sr2mux = 1'b0; addr1mux = 1'b0;
        mem_start = 1'b0; mem_we = 1'b0; mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 16'h0000;
`ifdef DP_BREAKPOINT_EN
        bp_addr = 16'h0000; bp_arm = 1'b0;
`endif
        step();
        step();
        Reset = 1'b0;

        // Reset state
        chk("rst_mar",  {16'h0, MAR}, 32'h0000_FFFF);
        chk("rst_ir",   {16'h0, IR},  32'h0);
        chk("rst_mdr",  {16'h0, MDR}, 32'h0);
        chk("rst_led",  {20'h0, LED}, 32'h0);
        chk("rst_ben",  {31'h0, BEN}, 32'h0);
        chk("rst_req",  {31'h0, mem_if.mem_req}, 32'h0);
        chk("rst_done", {31'h0, mem_done}, 32'h0);
        chk("rst_err",  {31'h0, mem_err},  32'h0);
        chk("rst_busy", {31'h0, mem_busy}, 32'h0);

        // gate[PC] puts PC_RESET on the bus; CC=Z makes BEN follow IR[10]
        gate = G_PC;
        #1;
        chk("no_conflict", {31'h0, bus_conflict}, 32'h0);
        xfer(L_IR, G_PC);
        chk("bus_pc_reset", {16'h0, IR}, 32'h0400);
        xfer(L_BEN, 4'h0);
        chk("ben_cc_reset_z", {31'h0, BEN}, 32'h1);

        // PC+1 and LED latch
        pcmux = 2'd0;
        xfer(L_PC, 4'h0);
        xfer(L_IR, G_PC);
        chk("pc_plus1", {16'h0, IR}, 32'h0401);
        xfer(L_LED, 4'h0);
        chk("led", {20'h0, LED}, 32'h401);

        // Address adder: PC(0x0401) + SEXT(off9=0x1FF) = 0x0400
        mem_read(16'h01FF);
        xfer(L_IR, G_MDR);
        addr1mux = 1'b0; addr2mux = 2'd2;
        xfer(L_IR, G_MARMUX);
        chk("addr_off9_neg", {16'h0, IR}, 32'h0400);

        // PC wraps from 0xFFFF to 0
        mem_read(16'hFFFF);
        pcmux = 2'd2;
        xfer(L_PC, G_MDR);
        pcmux = 2'd0;
        xfer(L_PC, 4'h0);
        xfer(L_IR, G_PC);
        chk("pc_wrap", {16'h0, IR}, 32'h0);

        // ALU: R1=0x7FFF, R2=1, R3=R1+R2 with CC update
        mem_read(16'h0200); xfer(L_IR, G_MDR);
        mem_read(16'h7FFF); xfer(L_REG, G_MDR);
        mem_read(16'h0400); xfer(L_IR, G_MDR);
        mem_read(16'h0001); xfer(L_REG, G_MDR);
        mem_read(16'h0642); xfer(L_IR, G_MDR);
        sr1mux = 1'b1; sr2mux = 1'b0; aluk = 2'd0;
        xfer(L_REG | L_CC, G_ALU);
        sr1mux = 1'b0; aluk = 2'd3;
        xfer(L_IR, G_ALU);
        chk("alu_add_r3", {16'h0, IR}, 32'h8000);
        mem_read(16'h0800); xfer(L_IR, G_MDR);
        xfer(L_BEN, 4'h0);
        chk("cc_n_ben", {31'h0, BEN}, 32'h1);
        mem_read(16'h0600); xfer(L_IR, G_MDR);
        xfer(L_BEN, 4'h0);
        chk("cc_not_zp_ben", {31'h0, BEN}, 32'h0);
        mem_read(16'h0400); xfer(L_IR, G_MDR);
        aluk = 2'd2;
        xfer(L_IR, G_ALU);
        chk("alu_not_r2", {16'h0, IR}, 32'hFFFE);

        // Read with ack after 5 REQ cycles
        mem_read(16'h0040);
        xfer(L_MAR, G_MDR);
        chk("mar_load", {16'h0, MAR}, 32'h0040);
        mem_start = 1'b1; mem_we = 1'b0;
        step();
        mem_start = 1'b0;
        chk("rd_addr", {16'h0, mem_if.mem_addr}, 32'h0040);
        chk("rd_wr",   {31'h0, mem_if.mem_wr},   32'h0);
        req_cnt = 0;
        while (mem_if.mem_req && req_cnt < 20) begin
            req_cnt++;
            if (req_cnt == 5) begin
                mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hBEEF;
            end
            step();
            mem_if.mem_ack = 1'b0;
        end
        chk("rd_req_cycles", req_cnt, 32'd5);
        chk("rd_mdr_beef",   {16'h0, MDR}, 32'hBEEF);
        chk("rd_done_hi",    {31'h0, mem_done}, 32'h1);
        step();
        chk("rd_done_lo",    {31'h0, mem_done}, 32'h0);
        chk("rd_busy_lo",    {31'h0, mem_busy}, 32'h0);

        // ld[MDR] ignored in REQ; read ack beats ld[MDR] on the same edge
        mem_start = 1'b1;
        step();
        mem_start = 1'b0;
        xfer(L_MDR, G_PC);
        chk("mdr_ignored_req", {16'h0, MDR}, 32'hBEEF);
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h1357;
        xfer(L_MDR, G_PC);
        mem_if.mem_ack = 1'b0;
        chk("mdr_ack_priority", {16'h0, MDR}, 32'h1357);
        step();

        // Bus conflict and MAR frozen during REQ
        gate = 4'b1100;
        #1;
        chk("conflict_flag", {31'h0, bus_conflict}, 32'h1);
        xfer(L_IR, 4'b1100);
        chk("conflict_bus0", {16'h0, IR}, 32'h0);
        mem_read(16'h1234);
        mem_start = 1'b1;
        step();
        mem_start = 1'b0;
        xfer(L_MAR, G_MDR);
        chk("mar_frozen", {16'h0, MAR}, 32'h0040);
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h1234;
        step();
        mem_if.mem_ack = 1'b0;
        step();

        // Timeout: no ack for TIMEOUT_CYC cycles
        mem_start = 1'b1;
        step();
        mem_start = 1'b0;
        req_cnt = 0;
        while (mem_if.mem_req && req_cnt < 200) begin
            req_cnt++;
            step();
        end
        chk("to_req_cycles", req_cnt, 32'd64);
        chk("to_err",        {31'h0, mem_err},  32'h1);
        chk("to_done_hi",    {31'h0, mem_done}, 32'h1);
        step();
        chk("to_done_lo",    {31'h0, mem_done}, 32'h0);
        step();
        step();
        chk("to_err_sticky", {31'h0, mem_err},  32'h1);

        // Reset mid-access, then a late ack in IDLE is ignored
        mem_start = 1'b1;
        step();
        mem_start = 1'b0;
        chk("mid_req", {31'h0, mem_if.mem_req}, 32'h1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mid_rst_req",  {31'h0, mem_if.mem_req}, 32'h0);
        chk("mid_rst_busy", {31'h0, mem_busy}, 32'h0);
        chk("mid_rst_err",  {31'h0, mem_err},  32'h0);
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hDEAD;
        step();
        mem_if.mem_ack = 1'b0;
        chk("late_ack_done", {31'h0, mem_done}, 32'h0);
        chk("late_ack_mdr",  {16'h0, MDR}, 32'h0);

`ifdef DP_BREAKPOINT_EN
        // Breakpoint on PC load of 0x3003
        bp_addr = 16'h3003; bp_arm = 1'b1;
        mem_read(16'h3000);
        pcmux = 2'd2;
        xfer(L_PC, G_MDR);
        chk("bp_3000", {31'h0, bp_hit}, 32'h0);
        pcmux = 2'd0;
        xfer(L_PC, 4'h0);
        xfer(L_PC, 4'h0);
        chk("bp_3002", {31'h0, bp_hit}, 32'h0);
        xfer(L_PC, 4'h0);
        chk("bp_3003", {31'h0, bp_hit}, 32'h1);
        xfer(L_PC, 4'h0);
        chk("bp_sticky", {31'h0, bp_hit}, 32'h1);
        bp_arm = 1'b0;
        step();
        chk("bp_disarm", {31'h0, bp_hit}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
